// File: rtl/systolic_mem_responder_pkg.sv
// Shared types for the systolic array: controller state and memory responder state.
package SystolicTypes;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_LOAD,
    CTRL_COMPUTE,
    CTRL_DRAIN
  } ctrl_state_t;

  typedef enum logic [1:0] {
    IDLE_R,
    HOST_R,
    START_R,
    RUN_R
  } mem_resp_state_t;

  // Increment that sticks at lim so stray extra writes cannot wrap the count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/systolic_mem_responder_sysmem_ram.sv
// Word storage: one async read port, one registered read port, one sync write port.
// Contents are never reset; only the registered read data is.
module sysmem_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    araddr,
  output logic [WIDTH-1:0] ardata,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_q
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign ardata = mem_q[araddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= rd_zero ? '0 : mem_q[rd_addr];
  end

endmodule

// File: rtl/systolic_mem_responder.sv
// Memory responder between a systolic controller and a host: host access arbitration,
// multiply start handshake and result-window write counting. Optional: SYSMEM_BOUNDS_CHECK_EN.
module systolic_mem_responder
  import SystolicTypes::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] act_addr,
  input  logic              mem_write,
  input  logic [WIDTH-1:0]  mem_data_write,
  output logic [WIDTH-1:0]  mem_read,
  input  logic [ADDR_W-1:0] addr_C,
  output logic              new_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic [WIDTH-1:0]  host_rdata,
  output logic              host_ack,
  input  logic              host_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  NN_CNT = CNT_W'(N * N);
  localparam logic [ADDR_W:0]   NN_EXT = (ADDR_W + 1)'(N * N);

  mem_resp_state_t  state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_data_q, new_data_d;
  logic             host_ack_q, host_ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ram_we, rd_en;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata, ram_ardata;
  logic             act_oob, host_oob;
  logic [ADDR_W:0]  c_end;
  logic             in_win;

  // Window end is one bit wider so a window near the top of the address space cannot wrap.
  assign c_end  = {1'b0, addr_C} + NN_EXT;
  assign in_win = (act_addr >= addr_C) && ({1'b0, act_addr} < c_end);

`ifdef SYSMEM_BOUNDS_CHECK_EN
  logic err_q, err_set;
  assign act_oob  = {1'b0, act_addr}  >= (ADDR_W + 1)'(DEPTH);
  assign host_oob = {1'b0, host_addr} >= (ADDR_W + 1)'(DEPTH);
  assign err_set  = ((state_q == HOST_R) && host_oob) ||
                    ((state_q == RUN_R) && mem_write && act_oob);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic host_addr_unused;
  assign act_oob          = 1'b0;
  assign host_oob         = 1'b0;
  assign host_addr_unused = ^host_addr;
  assign err              = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    new_data_d = 1'b0;
    host_ack_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = act_addr[AW-1:0];
    ram_wdata  = mem_data_write;
    rd_en      = 1'b0;
    case (state_q)
      IDLE_R: begin
        if (host_req) begin
          state_d = HOST_R;
          if (host_start) pend_d = 1'b1;
        end else if (host_start || pend_q) begin
          state_d    = START_R;
          pend_d     = 1'b0;
          cnt_d      = '0;
          new_data_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      HOST_R: begin
        state_d    = IDLE_R;
        host_ack_d = 1'b1;
        if (host_start) pend_d = 1'b1;
        if (host_we) begin
          ram_we    = !host_oob;
          ram_waddr = host_addr[AW-1:0];
          ram_wdata = host_wdata;
        end else begin
          rd_en = 1'b1;
        end
      end
      START_R: state_d = RUN_R;
      RUN_R: begin
        if (mem_write) begin
          ram_we = !act_oob;
          if (in_win) begin
            cnt_d = sat_inc(cnt_q, NN_CNT);
            if (cnt_d == NN_CNT) begin
              state_d = IDLE_R;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE_R;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_R;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      new_data_q <= 1'b0;
      host_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      new_data_q <= new_data_d;
      host_ack_q <= host_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sysmem_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .araddr   (act_addr[AW-1:0]),
    .ardata   (ram_ardata),
    .rd_en    (rd_en),
    .rd_zero  (host_oob),
    .rd_addr  (host_addr[AW-1:0]),
    .rd_data_q(host_rdata)
  );

  assign mem_read = act_oob ? '0 : ram_ardata;
  assign new_data = new_data_q;
  assign host_ack = host_ack_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/systolic_mem_responder.md
SYSTOLIC_MEM_RESPONDER -- requirements
Module: systolic_mem_responder

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the systolic array dimension; the C window is N*N words.
REQ-002 The module SHALL have parameter WIDTH, default 16, meaning the signed data word width.
REQ-003 The module SHALL have parameter DEPTH, default 256, meaning the number of storage words; DEPTH SHALL be a power of two and at most 4096.
REQ-004 The ports SHALL be exactly these, clock and reset first:
clk  in  1  single clock; all state changes on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
act_addr  in  12  controller word address.
mem_write  in  1  controller write strobe.
mem_data_write  in  WIDTH  controller write data.
mem_read  out  WIDTH  read data at act_addr.
addr_C  in  12  base address of the result window.
new_data  out  1  one-cycle start pulse to the controller.
host_req  in  1  host access request.
host_we  in  1  host write (1) or read (0).
host_addr  in  12  host word address.
host_wdata  in  WIDTH  host write data.
host_rdata  out  WIDTH  host read data, valid with host_ack.
host_ack  out  1  one-cycle completion pulse.
host_start  in  1  host request to start a multiply.
busy  out  1  high from new_data until done.
done  out  1  one-cycle pulse when N*N result words have been written.
err  out  1  sticky address-range error flag.

Function
REQ-005 mem_read SHALL be combinational from act_addr, with zero-cycle latency, so that data is valid in the same cycle the address is presented.
REQ-006 When mem_write is 1 and the state is RUN, the rising edge SHALL write mem_data_write to act_addr.
REQ-007 Controller writes outside RUN SHALL be ignored.
REQ-008 The FSM SHALL have states IDLE, HOST, START and RUN.
REQ-009 In IDLE, host_req SHALL take priority and move the FSM to HOST; a host_start seen in the same cycle SHALL be latched as pending.
REQ-010 In HOST, the access SHALL be performed, host_ack SHALL pulse for one cycle, host_rdata SHALL be registered with the word read, and the FSM SHALL return to IDLE. Host access latency is 2 cycles from the sampled request to host_ack.
REQ-011 In IDLE, with host_req low and host_start high or pending, the FSM SHALL enter START, clear the pending flag and clear the result counter.
REQ-012 START SHALL assert new_data for exactly one cycle, assert busy, and go to RUN.
REQ-013 In RUN, each write with addr_C <= act_addr < addr_C+N*N SHALL increment an 8-bit result counter.
REQ-014 When the counter reaches N*N, done SHALL pulse in the cycle after the last write, busy SHALL drop in the same cycle, and the FSM SHALL return to IDLE.
REQ-015 Host requests during START or RUN SHALL be held unacknowledged, with no access performed, and SHALL be served after return to IDLE.
REQ-016 host_start during START or RUN SHALL be ignored and SHALL NOT be latched.
REQ-017 A repeated write to the same C address SHALL count again; the counter SHALL saturate at N*N.
REQ-018 Address comparisons SHALL be unsigned 12-bit, and addr_C+N*N SHALL be computed in 13 bits so there is no wrap-around.

Reset
REQ-019 When rst_n is low, the FSM SHALL go to IDLE, and counter, pending flag, new_data, host_ack, host_rdata, busy, done and err SHALL all be 0, asynchronously.
REQ-020 Storage contents SHALL NOT be reset.
REQ-021 A reset during RUN SHALL abandon the operation without a done pulse.

Configuration
REQ-022 With macro SYSMEM_BOUNDS_CHECK_EN defined, any controller or host access with address >= DEPTH SHALL set err, which stays set until reset; such writes SHALL be suppressed, and such reads SHALL return 0.
REQ-023 Without SYSMEM_BOUNDS_CHECK_EN, addresses SHALL be taken modulo DEPTH and err SHALL be tied to 0.

Structure
REQ-024 The enum mem_resp_state_t (IDLE_R, HOST_R, START_R, RUN_R encodings of the REQ-008 states) SHALL be added to package SystolicTypes alongside the existing controller state type.
REQ-025 The storage array SHALL be a sub-module sysmem_ram with one asynchronous read port, one registered read port and one synchronous write port. The FSM, counter and arbitration SHALL stay in systolic_mem_responder.

Verification
REQ-026 The bench SHALL cover: host write 0x0005 to address 3, then host read of address 3 -> host_ack two cycles after each sampled request, and host_rdata = 0x0005.
REQ-027 The bench SHALL cover: act_addr=3 with no clock edge -> mem_read = 0x0005 in the same cycle.
REQ-028 The bench SHALL cover: addr_C=32, host_start, then 16 controller writes to addresses 32..47 -> new_data high for 1 cycle, busy high throughout, and done pulses the cycle after the 16th write.
REQ-029 The bench SHALL cover: host_req during RUN -> no host_ack until after done, then ack 2 cycles after IDLE.
REQ-030 The bench SHALL cover: host_req and host_start in the same IDLE cycle -> host access acked first, then new_data pulses.
REQ-031 The bench SHALL cover, with SYSMEM_BOUNDS_CHECK_EN and DEPTH=256: host write to address 300 -> err=1, address 44 unchanged; rst_n low mid-RUN -> busy=0 and no done pulse.
